// File: rtl/rsc_frame_encoder.sv
// Recursive systematic convolutional constituent encoder with frame counting,
// automatic trellis termination and valid/ready handshakes on both sides.
module rsc_frame_encoder #(
    parameter int         M         = 3,
    parameter logic [M:0] FB_POLY   = 4'b1101,
    parameter logic [M:0] FF_POLY   = 4'b1011,
    parameter int         FRAME_LEN = 40
) (
    input  logic clk,
    input  logic clr,
    input  logic enable,
    input  logic start,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sys,
    output logic out_par,
    output logic out_tail,
    output logic out_last,
    output logic busy
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TW = $clog2(M);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LAST_TAIL = TW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // s_q[i-1] holds shift-register stage s[i]; s_q[0] is the most recent stage
    logic [M-1:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sys_q, out_sys_d;
    logic          out_par_q, out_par_d;
    logic          out_tail_q, out_tail_d;
    logic          out_last_q, out_last_d;

    logic          out_free_s;
    logic          data_step_s;
    logic          tail_step_s;
    logic          fb_s;
    logic          u_s;
    logic          a_s;
    logic          z_s;

    function automatic logic fb_taps(input logic [M-1:0] s);
        logic acc;
        acc = 1'b0;
        for (int i = 1; i <= M; i++) begin
            acc = acc ^ (FB_POLY[i] & s[i-1]);
        end
        return acc;
    endfunction

    function automatic logic ff_parity(input logic a, input logic [M-1:0] s);
        logic acc;
        acc = FF_POLY[0] & a;
        for (int i = 1; i <= M; i++) begin
            acc = acc ^ (FF_POLY[i] & s[i-1]);
        end
        return acc;
    endfunction

    assign out_free_s  = !out_valid_q || out_ready;
    assign in_ready    = enable && (state_q == DATA) && out_free_s;
    assign data_step_s = in_ready && in_valid;
    assign tail_step_s = enable && (state_q == TAIL) && out_free_s;

    // Tail steps feed back the register taps so the feedback bit cancels to zero
    assign fb_s = fb_taps(s_q);
    assign u_s  = tail_step_s ? fb_s : in_bit;
    assign a_s  = u_s ^ fb_s;
    assign z_s  = ff_parity(a_s, s_q);

    // Next-state logic for the FSM, shift register, counters and output register
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        out_valid_d = out_valid_q;
        out_sys_d   = out_sys_q;
        out_par_d   = out_par_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = DATA;
                        s_d     = {M{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        tcnt_d  = {TW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (data_step_s) begin
                        s_d = {s_q[M-2:0], a_s};
                        if (cnt_q == LAST_BIT) begin
                            state_d = TAIL;
                            cnt_d   = {CW{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        s_d = s_q;
                    end
                end
                TAIL: begin
                    if (tail_step_s) begin
                        s_d = {s_q[M-2:0], a_s};
                        if (tcnt_q == LAST_TAIL) begin
                            state_d = IDLE;
                            tcnt_d  = {TW{1'b0}};
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end else begin
                        s_d = s_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (data_step_s || tail_step_s) begin
                out_valid_d = 1'b1;
                out_sys_d   = u_s;
                out_par_d   = z_s;
                out_tail_d  = tail_step_s;
                out_last_d  = tail_step_s && (tcnt_q == LAST_TAIL);
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                out_sys_d   = 1'b0;
                out_par_d   = 1'b0;
                out_tail_d  = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            s_q         <= {M{1'b0}};
            cnt_q       <= {CW{1'b0}};
            tcnt_q      <= {TW{1'b0}};
            out_valid_q <= 1'b0;
            out_sys_q   <= 1'b0;
            out_par_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_sys_q   <= out_sys_d;
            out_par_q   <= out_par_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sys   = out_sys_q;
    assign out_par   = out_par_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Directed-table and random-frame bench for rsc_frame_encoder (FRAME_LEN 4 and 40, M 3 and 4).
module tb_rsc_frame_encoder;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic enable = 1'b1;
    logic start_p = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b1;
    int   cur = 0;

    logic [2:0] st_w, irdy_w, ov_w, sys_w, par_w, tail_w, last_w, busy_w, sz_w;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] cap_q[$];
    logic [3:0] exp_q[$];

    typedef struct {
        string      name;
        logic [3:0] bits;
        logic [6:0] sys;
        logic [6:0] par;
        logic [6:0] tail;
        logic [6:0] last;
        int         rdy;
        bit         frz;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    assign st_w = start_p ? (3'b001 << cur) : 3'b000;

    rsc_frame_encoder #(.M(3), .FRAME_LEN(4)) dut4 (
        .clk(clk), .clr(clr), .enable(enable), .start(st_w[0]),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(irdy_w[0]),
        .out_valid(ov_w[0]), .out_ready(out_ready), .out_sys(sys_w[0]),
        .out_par(par_w[0]), .out_tail(tail_w[0]), .out_last(last_w[0]), .busy(busy_w[0])
    );

    rsc_frame_encoder #(.M(3), .FRAME_LEN(40)) dut40a (
        .clk(clk), .clr(clr), .enable(enable), .start(st_w[1]),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(irdy_w[1]),
        .out_valid(ov_w[1]), .out_ready(out_ready), .out_sys(sys_w[1]),
        .out_par(par_w[1]), .out_tail(tail_w[1]), .out_last(last_w[1]), .busy(busy_w[1])
    );

    rsc_frame_encoder #(.M(4), .FB_POLY(5'b10011), .FF_POLY(5'b11101), .FRAME_LEN(40)) dut40b (
        .clk(clk), .clr(clr), .enable(enable), .start(st_w[2]),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(irdy_w[2]),
        .out_valid(ov_w[2]), .out_ready(out_ready), .out_sys(sys_w[2]),
        .out_par(par_w[2]), .out_tail(tail_w[2]), .out_last(last_w[2]), .busy(busy_w[2])
    );

    assign sz_w = {(dut40b.s_q == 4'd0), (dut40a.s_q == 3'd0), (dut4.s_q == 3'd0)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs_of(input int k);
        return {ov_w[k], sys_w[k], par_w[k], tail_w[k], last_w[k], busy_w[k], irdy_w[k]};
    endfunction

    // Bit-accurate reference: polynomials use bit i as the D^i coefficient.
    task automatic model_frame(input int m, input logic [8:0] fb, input logic [8:0] ff,
                               input int nbits, input logic [39:0] data);
        logic [8:1] s;
        logic u, f, a, z;
        exp_q.delete();
        s = 8'd0;
        for (int k = 0; k < nbits + m; k++) begin
            f = 1'b0;
            for (int i = 1; i <= m; i++) f = f ^ (fb[i] & s[i]);
            u = (k < nbits) ? data[nbits-1-k] : f;
            a = u ^ f;
            z = ff[0] & a;
            for (int i = 1; i <= m; i++) z = z ^ (ff[i] & s[i]);
            exp_q.push_back({u, z, (k >= nbits), (k == nbits + m - 1)});
            for (int i = m; i >= 2; i--) s[i] = s[i-1];
            s[1] = a;
        end
    endtask

    task automatic run_frame(input string name, input int nbits, input int m,
                             input logic [39:0] data, input int rdy_mode, input bit frz);
        int  idx;
        int  cyc;
        bit  frozen;
        cap_q.delete();
        enable = 1'b1;
        out_ready = 1'b1;
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        check({name, "_busy_rise"}, 32'(busy_w[cur]), 32'd1);
        idx = 0;
        cyc = 0;
        while (cap_q.size() < nbits + m && cyc < 400) begin
            frozen   = frz && ((cyc >= 2 && cyc <= 4) || (cyc >= 8 && cyc <= 10));
            enable   = !frozen;
            start_p  = (cyc == 1);
            in_valid = (idx < nbits);
            in_bit   = (idx < nbits) ? data[nbits-1-idx] : 1'b0;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (frozen) out_ready = 1'b0;
            #1;
            if (frozen) begin
                check({name, "_frz_in_ready"}, 32'(irdy_w[cur]), 32'd0);
                check({name, "_frz_out_valid"}, 32'(ov_w[cur]), 32'd1);
                check({name, "_frz_busy"}, 32'(busy_w[cur]), 32'd1);
            end
            if (ov_w[cur] && !out_ready)
                check({name, "_stall_in_ready"}, 32'(irdy_w[cur]), 32'd0);
            if (enable && in_valid && irdy_w[cur]) idx++;
            if (enable && ov_w[cur] && out_ready)
                cap_q.push_back({sys_w[cur], par_w[cur], tail_w[cur], last_w[cur]});
            @(posedge clk); #1;
            cyc++;
        end
        start_p  = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({name, "_beats"}, 32'(cap_q.size()), 32'(nbits + m));
        check({name, "_busy_fall"}, 32'(busy_w[cur]), 32'd0);
        check({name, "_s_zero"}, 32'(sz_w[cur]), 32'd1);
        check({name, "_out_valid_clear"}, 32'(ov_w[cur]), 32'd0);
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    task automatic load_table_exp(input int t);
        exp_q.delete();
        for (int b = 0; b < 7; b++)
            exp_q.push_back({tbl[t].sys[6-b], tbl[t].par[6-b], tbl[t].tail[6-b], tbl[t].last[6-b]});
    endtask

    initial begin
        logic [39:0] d;
        tbl[0] = '{"impulse",      4'b1000, 7'b1000101, 7'b1111111, 7'b0000111, 7'b0000001, 0, 1'b0};
        tbl[1] = '{"zeros",        4'b0000, 7'b0000000, 7'b0000000, 7'b0000111, 7'b0000001, 0, 1'b0};
        tbl[2] = '{"backpressure", 4'b1000, 7'b1000101, 7'b1111111, 7'b0000111, 7'b0000001, 1, 1'b0};
        tbl[3] = '{"freeze",       4'b1000, 7'b1000101, 7'b1111111, 7'b0000111, 7'b0000001, 0, 1'b1};
        tbl[4] = '{"mixed",        4'b1101, 7'b1101001, 7'b1001011, 7'b0000111, 7'b0000001, 0, 1'b0};

        #3;
        for (int k = 0; k < 3; k++) check($sformatf("reset_outs%0d", k), 32'(outs_of(k)), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy_w), 32'd0);

        cur = 0;
        for (int t = 0; t < 5; t++) begin
            load_table_exp(t);
            run_frame(tbl[t].name, 4, 3, {36'd0, tbl[t].bits}, tbl[t].rdy, tbl[t].frz);
            @(posedge clk); #1;
        end

        // Abort after two of four bits, then repeat the impulse frame
        cur = 0;
        start_p = 1'b1;
        @(posedge clk); #1;
        start_p = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk); #1;
        in_bit = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_pre_valid", 32'({ov_w[0], busy_w[0]}), 32'd3);
        #2;
        clr = 1'b1;
        #1;
        check("abort_outs_async", 32'(outs_of(0)), 32'd0);
        @(posedge clk); #2;
        clr = 1'b0;
        check("abort_outs_next", 32'(outs_of(0)), 32'd0);
        check("abort_s_zero", 32'(sz_w[0]), 32'd1);
        @(posedge clk); #1;
        load_table_exp(0);
        run_frame("post_abort", 4, 3, {36'd0, tbl[0].bits}, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            cur = (r < 3) ? 1 : 2;
            d[31:0]  = $urandom();
            d[39:32] = 8'($urandom());
            if (cur == 1) model_frame(3, 9'b000001101, 9'b000001011, 40, d);
            else          model_frame(4, 9'b000010011, 9'b000011101, 40, d);
            @(posedge clk); #1;
            run_frame($sformatf("rand%0d_m%0d", r, (cur == 1) ? 3 : 4), 40, (cur == 1) ? 3 : 4, d, 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsc_frame_encoder.md
# rsc_frame_encoder

Parametrised recursive systematic convolutional (RSC) constituent encoder for the turbo encoder datapath. It generalises the fixed 3-register encoder with four additions: configurable memory depth and generator polynomials, frame-length counting, automatic trellis termination (M tail cycles), and a valid/ready handshake on both sides. Two instances are used per turbo encoder: one on natural-order data and one behind the interleaver.

## Interface
Parameters:
- M, 3: encoder memory (number of shift-register stages), 2..8.
- FB_POLY, 4'b1101: feedback polynomial, width M+1.
  - Bit i is the coefficient of D^i.
  - Bit 0 must be 1.
  - The default is 1+D^2+D^3.
- FF_POLY, 4'b1011: feedforward (parity) polynomial, width M+1, same bit convention. The default is 1+D+D^3.
- FRAME_LEN, 40: information bits per frame, 1..6144.

Ports:
- clk, input, 1: clock, rising edge.
- clr, input, 1: asynchronous, active-high reset.
- enable, input, 1: global clock enable. When low, all state and outputs hold.
- start, input, 1: one-cycle pulse that begins a frame. Sampled only in IDLE.
- in_valid, input, 1: in_bit is valid.
- in_bit, input, 1: information bit u.
- in_ready, output, 1: the encoder accepts in_bit this cycle.
- out_valid, output, 1: the output pair is valid.
- out_ready, input, 1: the downstream block accepts the output pair.
- out_sys, output, 1: systematic bit (Xk).
- out_par, output, 1: parity bit (Zk).
- out_tail, output, 1: the current output pair is a termination bit.
- out_last, output, 1: the current output pair is the final tail bit of the frame.
- busy, output, 1: state is not IDLE.

## Operation
- Shift-register state s[1..M]: s[1] is the most recent stage. It is all zeros at reset and at every start.
- Encoding step for input u:
  - Feedback bit: a = u XOR (XOR over i=1..M of FB_POLY[i]&s[i]).
  - Parity: z = (FF_POLY[0]&a) XOR (XOR over i=1..M of FF_POLY[i]&s[i]).
  - State update: s[1]<=a, s[i]<=s[i-1].
  - Systematic bit: x = u.
- Tail step: u is replaced by f = XOR over i=1..M of FB_POLY[i]&s[i]. This forces a=0. The step outputs x=f and z as above.
- FSM states are IDLE, DATA and TAIL.
  - IDLE: start=1 clears s and the bit counter, then goes to DATA. A start pulse outside IDLE is ignored.
  - DATA: each handshake (in_valid & in_ready) encodes one bit and increments the counter. The transfer of bit FRAME_LEN-1 goes to TAIL.
  - TAIL: one tail step is taken each cycle the output register is free (!out_valid | out_ready). After M steps the FSM returns to IDLE, and s is then all zeros.
- in_ready = enable & (state==DATA) & (!out_valid | out_ready). It is low in IDLE and TAIL.
- Output register:
  - It is loaded with {x, z, tail flag, last flag} on each encode or tail step, and out_valid is set.
  - It is cleared (out_valid=0) on out_ready when no new step occurs.
  - It holds while out_valid & !out_ready.
- enable=0 freezes the FSM, s, the counter and the output register. in_ready is forced to 0. out_valid holds its value.

## Timing
- Reset values: out_valid=0, out_sys=0, out_par=0, out_tail=0, out_last=0, busy=0, in_ready=0, state=IDLE, s=0, counter=0.
- Latency: an input bit accepted at clock edge k appears on out_sys/out_par after edge k, one cycle.
- Throughput: one bit per cycle with out_ready held high. A frame occupies FRAME_LEN+M output beats.
- busy rises the cycle after start. It falls the cycle after the last tail step is loaded.
- A start pulse in the cycle busy falls is ignored. The earliest new start is sampled while busy=0.
- Asserting clr mid-frame aborts the frame immediately and all outputs take their reset values. No partial tail is emitted.
- Simultaneous out_ready and a new step: the output register is loaded with the new step, and out_valid stays 1.

## Test plan
- Defaults with FRAME_LEN=4, input 1,0,0,0, out_ready=1:
  - out_sys = 1,0,0,0,1,0,1.
  - out_par = 1,1,1,1,1,1,1.
  - out_tail = 0,0,0,0,1,1,1; out_last only on beat 7.
  - Final s=000.
- All-zero frame, FRAME_LEN=4: 7 beats with sys=0 and par=0, tail flags on beats 5-7, busy deasserts after beat 7.
- Backpressure: same stimulus as the first scenario, out_ready toggled 1,0,0,1,... The output sequence must be identical, with no loss or duplication, and in_ready=0 whenever out_valid & !out_ready.
- Reset mid-frame: clr after 2 of 4 bits. Next cycle all outputs are at their reset values. A new start with 1,0,0,0 reproduces the first scenario exactly.
- enable=0 for 3 cycles mid-DATA and mid-TAIL: all state and outputs hold. The output sequence equals the first scenario.
- Random frames, FRAME_LEN=40, M=3 and M=4 (FB=5'b10011, FF=5'b11101): the bench compares against a bit-accurate model and checks that s=0 after every tail.
